// File: rtl/mem_pkg.sv
// Shared types for the L1/L2 memory path: bus structs, arbiter state type and sizing helpers.
package mem_pkg;

  localparam int unsigned NUM_PORTS_DEF = 2;
  localparam int unsigned MEM_ADDR_W    = 32;
  localparam int unsigned MEM_BLOCK_W   = 128;

  typedef struct packed {
    logic                   valid;
    logic                   wen;
    logic [MEM_ADDR_W-1:0]  addr;
    logic [MEM_BLOCK_W-1:0] data;
  } CacheToMem_t;

  typedef struct packed {
    logic                   ready;
    logic [MEM_BLOCK_W-1:0] data;
  } MemToCache_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } arb_state_e;

  // Width of a port index; never below one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid port at or after last_grant+1, wrapping.
module rr_picker import mem_pkg::*; #(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     index_o
);

  int unsigned w_cand;

  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    w_cand  = 0;
    // Walk from the farthest candidate back so the nearest valid one is the last to win.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_cand = 32'(last_grant_i) + 32'(i) + 32'd1;
      if (w_cand >= NUM_PORTS) begin
        w_cand = w_cand - NUM_PORTS;
      end
      if (valid_i[IDX_W'(w_cand)]) begin
        found_o = 1'b1;
        index_o = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 port among NUM_PORTS L1 requesters, one transaction at a time.
module l1_l2_arbiter import mem_pkg::*; #(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BLOCK_W   = 128
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_PORTS-1:0]              req_valid_i,
  input  logic [NUM_PORTS-1:0]              req_wen_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_PORTS-1:0][BLOCK_W-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]              resp_ready_o,
  output logic [BLOCK_W-1:0]                resp_data_o,
  output logic                              l2_valid_o,
  output logic                              l2_wen_o,
  output logic [ADDR_W-1:0]                 l2_addr_o,
  output logic [BLOCK_W-1:0]                l2_data_o,
  input  logic                              l2_ready_i,
  input  logic [BLOCK_W-1:0]                l2_data_i
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);

  arb_state_e           r_state;
  logic [IDX_W-1:0]     r_last_grant;
  logic                 r_l2_valid;
  logic                 r_l2_wen;
  logic [ADDR_W-1:0]    r_l2_addr;
  logic [BLOCK_W-1:0]   r_l2_data;
  logic [NUM_PORTS-1:0] r_resp_ready;
  logic [BLOCK_W-1:0]   r_resp_data;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .valid_i      (req_valid_i),
    .last_grant_i (r_last_grant),
    .found_o      (w_found),
    .index_o      (w_pick)
  );

  // r_last_grant doubles as the index of the in-flight transaction's owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      r_l2_valid   <= 1'b0;
      r_l2_wen     <= 1'b0;
      r_l2_addr    <= '0;
      r_l2_data    <= '0;
      r_resp_ready <= '0;
      r_resp_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_last_grant <= w_pick;
            r_l2_valid   <= 1'b1;
            r_l2_wen     <= req_wen_i[w_pick];
            r_l2_addr    <= req_addr_i[w_pick];
            r_l2_data    <= req_data_i[w_pick];
            r_state      <= StBusy;
          end
        end
        StBusy: begin
          if (l2_ready_i) begin
            r_l2_valid   <= 1'b0;
            r_resp_data  <= l2_data_i;
            r_resp_ready <= NUM_PORTS'(1) << r_last_grant;
            r_state      <= StResp;
          end
        end
        StResp: begin
          r_resp_ready <= '0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign resp_ready_o = r_resp_ready;
  assign resp_data_o  = r_resp_data;
  assign l2_valid_o   = r_l2_valid;
  assign l2_wen_o     = r_l2_wen;
  assign l2_addr_o    = r_l2_addr;
  assign l2_data_o    = r_l2_data;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter (4 ports): directed scenarios plus random traffic against a transaction model.
module tb_l1_l2_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int BW = 128;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NP-1:0]          req_valid;
  logic [NP-1:0]          req_wen;
  logic [NP-1:0][AW-1:0]  req_addr;
  logic [NP-1:0][BW-1:0]  req_data;
  logic [NP-1:0]          resp_ready_o;
  logic [BW-1:0]          resp_data_o;
  logic                   l2_valid_o;
  logic                   l2_wen_o;
  logic [AW-1:0]          l2_addr_o;
  logic [BW-1:0]          l2_data_o;
  logic                   l2_ready;
  logic [BW-1:0]          l2_data;

  always #5 clk = ~clk;

  l1_l2_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .BLOCK_W   (BW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_wen_i    (req_wen),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .resp_ready_o (resp_ready_o),
    .resp_data_o  (resp_data_o),
    .l2_valid_o   (l2_valid_o),
    .l2_wen_o     (l2_wen_o),
    .l2_addr_o    (l2_addr_o),
    .l2_data_o    (l2_data_o),
    .l2_ready_i   (l2_ready),
    .l2_data_i    (l2_data)
  );

  // Transaction-level model: one outstanding transaction, its owner, and a pending pulse.
  bit          m_active;
  int          m_port;
  int          m_pulse;
  int          m_last;
  logic        m_wen;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;
  logic [BW-1:0] m_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulse_port[$];
  int pulse_cyc[$];

  task automatic model_reset();
    m_active = 0;
    m_port   = 0;
    m_pulse  = -1;
    m_last   = NP - 1;
    m_wen    = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_resp   = '0;
  endtask

  task automatic model_step();
    if (m_pulse >= 0) begin
      m_pulse = -1;
    end else if (m_active) begin
      if (l2_ready) begin
        m_resp   = l2_data;
        m_pulse  = m_port;
        m_active = 0;
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (req_valid[p]) begin
          m_active = 1;
          m_port   = p;
          m_last   = p;
          m_wen    = req_wen[p];
          m_addr   = req_addr[p];
          m_data   = req_data[p];
          break;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    logic [NP-1:0] e_ready;
    e_ready = '0;
    if (m_pulse >= 0) e_ready[m_pulse] = 1'b1;
    chk("l2_valid", l2_valid_o, m_active);
    chk("l2_wen", l2_wen_o, m_wen);
    chk("l2_addr", l2_addr_o, m_addr);
    chk("l2_data", l2_data_o, m_data);
    chk("resp_ready", resp_ready_o, e_ready);
    chk("resp_data", resp_data_o, m_resp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    cyc++;
    @(negedge clk);
    check_all();
    for (int p = 0; p < NP; p++) begin
      if (resp_ready_o[p]) begin
        pulse_port.push_back(p);
        pulse_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_data  = '0;
    l2_ready  = 1'b0;
    l2_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    pulse_port.delete();
    pulse_cyc.delete();
  endtask

  task automatic chk_pulses(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3, input int gap);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk($sformatf("%s_count", name), pulse_port.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < pulse_port.size()) begin
        chk($sformatf("%s_port%0d", name, i), pulse_port[i], e[i]);
        if (i > 0) chk($sformatf("%s_gap%0d", name, i), pulse_cyc[i] - pulse_cyc[i-1], gap);
      end
    end
  endtask

  function automatic logic [BW-1:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    clear_inputs();
    model_reset();
    tick();
    tick();
    chk("rst_l2_valid", l2_valid_o, 0);
    chk("rst_l2_addr", l2_addr_o, 0);
    chk("rst_resp_ready", resp_ready_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    rst = 1'b0;

    // Single read from port 0, L2 answers two cycles after the request appears.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h100;
    req_data[0]  = rnd_block();
    tick();
    chk("t1_l2_valid", l2_valid_o, 1);
    chk("t1_l2_addr", l2_addr_o, 32'h100);
    tick();
    tick();
    l2_ready = 1'b1;
    l2_data  = {4{32'hA5A5A5A5}};
    tick();
    chk("t1_resp_ready", resp_ready_o, 4'b0001);
    chk("t1_resp_data", resp_data_o, {4{32'hA5A5A5A5}});
    chk("t1_l2_valid_resp", l2_valid_o, 0);
    req_valid = '0;
    l2_ready  = 1'b0;
    l2_data   = '0;
    tick();
    chk("t1_pulse_end", resp_ready_o, 4'b0000);
    chk("t1_resp_hold", resp_data_o, {4{32'hA5A5A5A5}});

    // Ports 0 and 1 contend, L2 always ready: alternate every 3 cycles.
    do_reset();
    req_valid = 4'b0011;
    req_addr[0] = 32'h40;
    req_addr[1] = 32'h80;
    l2_ready = 1'b1;
    repeat (12) tick();
    chk_pulses("rr01", 4, 0, 1, 0, 1, 3);

    // Ports 1 and 3 contend: port 1 first, then wrap through 3 back to 1.
    do_reset();
    req_valid = 4'b1010;
    l2_ready  = 1'b1;
    repeat (9) tick();
    chk_pulses("rr13", 3, 1, 3, 1, -1, 3);

    // Sole requester back-to-back.
    do_reset();
    req_valid = 4'b0001;
    l2_ready  = 1'b1;
    repeat (9) tick();
    chk_pulses("b2b", 3, 0, 0, 0, -1, 3);

    // Port 1 write; its live inputs change mid-transaction and must not leak to L2.
    do_reset();
    req_valid[1] = 1'b1;
    req_wen[1]   = 1'b1;
    req_addr[1]  = 32'h200;
    req_data[1]  = rnd_block();
    tick();
    chk("t4_l2_addr0", l2_addr_o, 32'h200);
    chk("t4_l2_wen", l2_wen_o, 1);
    req_addr[1]  = 32'h300;
    req_valid[1] = 1'b0;
    tick();
    chk("t4_l2_addr1", l2_addr_o, 32'h200);
    tick();
    chk("t4_l2_addr2", l2_addr_o, 32'h200);
    l2_ready = 1'b1;
    l2_data  = rnd_block();
    tick();
    chk("t4_resp_ready", resp_ready_o, 4'b0010);
    chk("t4_l2_addr3", l2_addr_o, 32'h200);
    l2_ready = 1'b0;
    tick();

    // Reset in the middle of a transaction owned by port 2.
    do_reset();
    req_valid   = 4'b0100;
    req_addr[2] = 32'h2A0;
    req_addr[0] = 32'h0C0;
    tick();
    chk("t5_l2_addr", l2_addr_o, 32'h2A0);
    req_valid = 4'b0101;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_l2_valid", l2_valid_o, 0);
    chk("t5_rst_resp_ready", resp_ready_o, 0);
    tick();
    rst = 1'b0;
    pulse_port.delete();
    pulse_cyc.delete();
    l2_ready = 1'b1;
    tick();
    chk("t5_port0_first", l2_addr_o, 32'h0C0);
    tick();
    chk("t5_resp_ready", resp_ready_o, 4'b0001);
    chk_pulses("t5", 1, 0, -1, -1, -1, 0);

    // Random traffic with occasional withdrawals, address churn and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (resp_ready_o[p]) begin
          if ($urandom_range(3) == 0) begin
            req_wen[p]  = 1'($urandom);
            req_addr[p] = $urandom;
            req_data[p] = rnd_block();
          end else begin
            req_valid[p] = 1'b0;
          end
        end else if (req_valid[p]) begin
          if ($urandom_range(31) == 0) req_valid[p] = 1'b0;
          if ($urandom_range(7) == 0) req_addr[p] = $urandom;
        end else if ($urandom_range(3) == 0) begin
          req_valid[p] = 1'b1;
          req_wen[p]   = 1'($urandom);
          req_addr[p]  = $urandom;
          req_data[p]  = rnd_block();
        end
      end
      l2_ready = ($urandom_range(2) == 0);
      l2_data  = rnd_block();
      rst      = ($urandom_range(499) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
